// File: rtl/board_pkg.sv
// Shared constants and helpers for the board-I/O conditioning blocks.
package board_pkg;

    localparam int CLK_HZ      = 10_000_000;
    localparam int DEBOUNCE_MS = 10;

    // 10 ms at 10 MHz = 100_000 cycles.
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // Kind of stable-level change accepted on the current edge.
    typedef enum logic [1:0] {
        PULSE_NONE = 2'b00,
        PULSE_RISE = 2'b01,
        PULSE_FALL = 2'b10
    } pulse_e;

    // Counter width able to hold 0..cycles, never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit switch conditioner: 2-FF synchroniser, hold-time counter,
// accepted stable level and one-cycle rise/fall pulses.
module debounce_bit
    import board_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0_q, sync0_d;
    logic          sync1_q, sync1_d;
    logic          stable_q, stable_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    pulse_e        pulse_q, pulse_d;

    // Next-state: shift the synchroniser, count while the input disagrees, accept on the last count.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        sync0_d  = raw_i;
        sync1_d  = sync0_q;
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = PULSE_NONE;

        if (sync1_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync1_q;
                pulse_d  = sync1_q ? PULSE_RISE : PULSE_FALL;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Busy reflects the state after this edge, so it drops with the stable update.
        busy_d = (sync1_d != stable_d);
    end

    // State register with synchronous active-low reset; a reset discards any pending count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            sync0_q  <= RESET_VAL;
            sync1_q  <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
            pulse_q  <= PULSE_NONE;
            busy_q   <= 1'b0;
        end else begin
            sync0_q  <= sync0_d;
            sync1_q  <= sync1_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = (pulse_q == PULSE_RISE);
    assign fall_o   = (pulse_q == PULSE_FALL);
    assign busy_o   = busy_q;

endmodule

// File: rtl/switch_debounce.sv
// N independent switch debouncers feeding the register-file display top.
module switch_debounce
    import board_pkg::*;
#(
    parameter int           N               = 4,
    parameter int           DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [N-1:0] RESET_VAL       = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_stable,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic         sw_busy
);

    logic [N-1:0] busy_bits;

    for (genvar i = 0; i < N; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[i])
        ) u_bit (
            .clk      (clk),
            .resetn   (resetn),
            .raw_i    (sw_raw[i]),
            .stable_o (sw_stable[i]),
            .rise_o   (sw_rise[i]),
            .fall_o   (sw_fall[i]),
            .busy_o   (busy_bits[i])
        );
    end

    assign sw_busy = |busy_bits;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench: expected pulses are queued by the stimulus, a monitor
// pops and compares them whenever the DUT emits a rise/fall pulse.
module tb_switch_debounce;

    localparam int N   = 4;
    localparam int D   = 4;
    localparam int LAT = D + 2;

    logic         clk;
    logic         resetn;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_stable, sw_rise, sw_fall;
    logic         sw_busy;

    logic [N-1:0] sw_raw_rv;
    logic [N-1:0] sw_stable_rv, sw_rise_rv, sw_fall_rv;
    logic         sw_busy_rv;

    switch_debounce #(.N(N), .DEBOUNCE_CYCLES(D), .RESET_VAL(4'b0000)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_busy   (sw_busy)
    );

    switch_debounce #(.N(N), .DEBOUNCE_CYCLES(D), .RESET_VAL(4'b1010)) dut_rv (
        .clk       (clk),
        .resetn    (resetn),
        .sw_raw    (sw_raw_rv),
        .sw_stable (sw_stable_rv),
        .sw_rise   (sw_rise_rv),
        .sw_fall   (sw_fall_rv),
        .sw_busy   (sw_busy_rv)
    );

    typedef struct {
        int           edge_no;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] stable;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, output int base);
        sw_raw = v;
        base   = cyc;
    endtask

    task automatic expect_pulse(input int edge_no, input logic [N-1:0] r,
                                input logic [N-1:0] f, input logic [N-1:0] s);
        exp_t e;
        e.edge_no = edge_no;
        e.rise    = r;
        e.fall    = f;
        e.stable  = s;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse on the main DUT must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (sw_rise != '0 || sw_fall != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({sw_rise, sw_fall}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle",  32'(cyc),       32'(e.edge_no));
                check("pulse_rise",   32'(sw_rise),   32'(e.rise));
                check("pulse_fall",   32'(sw_fall),   32'(e.fall));
                check("pulse_stable", 32'(sw_stable), 32'(e.stable));
                check("pulse_busy",   32'(sw_busy),   32'd0);
            end
        end
        if (resetn === 1'b1)
            check("rv_no_pulse", 32'({sw_rise_rv, sw_fall_rv}), 32'd0);
    end

    initial begin
        int         base;
        logic [5:0] bounce;

        bounce    = 6'b101101;
        resetn    = 1'b0;
        sw_raw    = '0;
        sw_raw_rv = 4'b1010;
        idle(3);
        resetn = 1'b1;

        // 1. Quiet after reset release.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("rst_stable", 32'(sw_stable), 32'd0);
            check("rst_rise",   32'(sw_rise),   32'd0);
            check("rst_fall",   32'(sw_fall),   32'd0);
            check("rst_busy",   32'(sw_busy),   32'd0);
        end
        check("rv_stable", 32'(sw_stable_rv), 32'hA);
        check("rv_busy",   32'(sw_busy_rv),   32'd0);

        // 2. Clean 0->1 on bit0: accepted after edge 6, busy during edges 2..5.
        @(negedge clk);
        drive(4'b0001, base);
        expect_pulse(base + LAT, 4'b0001, 4'b0000, 4'b0001);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("toggle_busy",   32'(sw_busy),   32'((k >= 2) && (k <= 5)));
            check("toggle_stable", 32'(sw_stable), (k >= LAT) ? 32'd1 : 32'd0);
            if (k == LAT + 1)
                check("toggle_rise_clear", 32'(sw_rise), 32'd0);
        end

        // 3. Three-cycle glitch on bit1 is rejected.
        @(negedge clk);
        drive(4'b0011, base);
        idle(3);
        drive(4'b0001, base);
        idle(10);
        check("glitch_stable", 32'(sw_stable), 32'h1);
        check("glitch_busy",   32'(sw_busy),   32'd0);

        // 4. Bouncing rise on bit2 gives one pulse, then a clean fall.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive({1'b0, bounce[5 - i], 2'b01}, base);
        end
        expect_pulse(base + LAT, 4'b0100, 4'b0000, 4'b0101);
        idle(10);
        check("bounce_stable", 32'(sw_stable), 32'h5);
        drive(4'b0001, base);
        expect_pulse(base + LAT, 4'b0000, 4'b0100, 4'b0001);
        idle(10);
        check("bounce_fall_stable", 32'(sw_stable), 32'h1);

        // 5. Bit0 back low, then bits 0 and 3 rise on the same edge.
        drive(4'b0000, base);
        expect_pulse(base + LAT, 4'b0000, 4'b0001, 4'b0000);
        idle(10);
        drive(4'b1001, base);
        expect_pulse(base + LAT, 4'b1001, 4'b0000, 4'b1001);
        idle(10);
        check("simul_stable", 32'(sw_stable), 32'h9);

        // 6. Reset two cycles into a bit1 transition discards it.
        drive(4'b1011, base);
        idle(2);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_stable",    32'(sw_stable),    32'd0);
        check("midrst_busy",      32'(sw_busy),      32'd0);
        check("midrst_pulses",    32'({sw_rise, sw_fall}), 32'd0);
        check("midrst_rv_stable", 32'(sw_stable_rv), 32'hA);
        idle(1);
        resetn = 1'b1;
        base   = cyc;
        expect_pulse(base + LAT, 4'b1011, 4'b0000, 4'b1011);
        idle(10);
        check("post_rst_stable", 32'(sw_stable),    32'hB);
        check("post_rst_busy",   32'(sw_busy),      32'd0);
        check("rv_final_stable", 32'(sw_stable_rv), 32'hA);
        check("rv_final_busy",   32'(sw_busy_rv),   32'd0);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
